// File: rtl/pipeline_pkg.sv
// Shared definitions for the elastic pipeline registers between core stages.
package pipeline_pkg;

  typedef struct packed {
    logic [23:0] alu_result;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_bundle_t;

  localparam int PL_MAX_DEPTH = 4;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic int unsigned pl_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             sRST,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc && (value_q != '1)) value_d = value_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (sRST) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pipeline_elastic_reg.sv
// Elastic valid/ready pipeline register with a DEPTH-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipeline_elastic_reg
  import pipeline_pkg::*;
#(
  parameter int WIDTH = $bits(exmem_bundle_t),
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             sRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [2:0]       count_q, count_d;
  logic             push, pop, stall_inc;

  // in_ready depends only on stored state and flush, never on out_ready.
  assign in_ready  = (count_q < DEPTH_C) & ~flush;
  assign out_valid = (count_q != 3'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign stall_inc = out_valid & ~out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    if (pop)  rd_ptr_d = PW'(pl_wrap(32'(rd_ptr_q), DEPTH));
    if (push) wr_ptr_d = PW'(pl_wrap(32'(wr_ptr_q), DEPTH));
    if (flush) begin
      count_d  = 3'd0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (sRST) begin
      count_q  <= 3'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage has no reset; out_data is masked while empty instead.
  always_ff @(posedge CLK) begin
    if (!sRST && push) mem_q[wr_ptr_q] <= in_data;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .sRST  (sRST),
    .inc   (stall_inc),
    .value (stall_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!sRST) begin
      assert (count_q <= DEPTH_C);
      assert (!(push && (count_q == DEPTH_C)));
      assert (!(pop && (count_q == 3'd0)));
    end
  end

endmodule

// File: tb/tb_pipeline_elastic_reg.sv
// Directed and scoreboard checks of pipeline_elastic_reg in three configurations.
module tb_pipeline_elastic_reg;

  logic CLK = 1'b0;
  logic sRST = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  // a_: DEPTH=2, CNT_W=16
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;
  logic [15:0] a_stall;
  // s_: DEPTH=2, CNT_W=4
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [2:0]  s_count;
  logic [3:0]  s_stall;
  // c_: DEPTH=3, CNT_W=16
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [2:0]  c_count;
  logic [15:0] c_stall;

  pipeline_elastic_reg #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_a (
    .CLK(CLK), .sRST(sRST), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .count(a_count), .stall_cnt(a_stall));

  pipeline_elastic_reg #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_s (
    .CLK(CLK), .sRST(sRST), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .count(s_count), .stall_cnt(s_stall));

  pipeline_elastic_reg #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) u_c (
    .CLK(CLK), .sRST(sRST), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .count(c_count), .stall_cnt(c_stall));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    a_flush = 0; a_in_valid = 1; a_in_data = 32'h55; a_out_ready = 0;
    s_flush = 0; s_in_valid = 1; s_in_data = 32'h66; s_out_ready = 0;
    c_flush = 0; c_in_valid = 1; c_in_data = 32'h77; c_out_ready = 0;
    sRST = 1;
    repeat (3) tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b expected 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %0h expected 0", a_out_data); end
    n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", a_count); end
    n_cmp++; if (a_stall !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d expected 0", a_stall); end
    n_cmp++; if (c_count !== 3'd0) begin n_err++; $display("FAIL reset_count_d3: got %0d expected 0", c_count); end
    a_in_valid = 0; s_in_valid = 0; c_in_valid = 0;
    sRST = 0;
    tick();
    n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", a_in_ready); end
    n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL reset_count_after: got %0d expected 0", a_count); end
    n_cmp++; if (s_stall !== 4'd0) begin n_err++; $display("FAIL reset_stall_sat: got %0d expected 0", s_stall); end
  endtask

  task automatic test_streaming();
    a_out_ready = 1;
    for (int i = 0; i <= 16; i++) begin
      a_in_valid = (i < 16);
      a_in_data  = 32'(i + 1);
      #1;
      if (i < 16) begin
        n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, a_in_ready); end
      end
      n_cmp++; if (a_out_valid !== (i > 0)) begin n_err++; $display("FAIL stream_out_valid[%0d]: got %0b expected %0b", i, a_out_valid, (i > 0)); end
      if (i > 0) begin
        n_cmp++; if (a_out_data !== 32'(i)) begin n_err++; $display("FAIL stream_out_data[%0d]: got %0h expected %0h", i, a_out_data, i); end
      end
      tick();
    end
    a_in_valid = 0;
    n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL stream_drained: got %0d expected 0", a_count); end
    n_cmp++; if (a_stall !== 16'd0) begin n_err++; $display("FAIL stream_stall: got %0d expected 0", a_stall); end
  endtask

  task automatic test_back_pressure();
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'hA;
    tick();
    a_in_data = 32'hB;
    tick();
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_count !== 3'd2) begin n_err++; $display("FAIL bp_count: got %0d expected 2", a_count); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %0b expected 0", a_in_ready); end
    n_cmp++; if (a_stall !== 16'd1) begin n_err++; $display("FAIL bp_stall_start: got %0d expected 1", a_stall); end
    for (int k = 2; k <= 4; k++) begin
      tick();
      n_cmp++; if (a_stall !== 16'(k)) begin n_err++; $display("FAIL bp_stall_inc: got %0d expected %0d", a_stall, k); end
    end
    n_cmp++; if (a_out_data !== 32'hA) begin n_err++; $display("FAIL bp_first: got %0h expected a", a_out_data); end
    a_out_ready = 1;
    tick();
    n_cmp++; if (a_out_data !== 32'hB) begin n_err++; $display("FAIL bp_second: got %0h expected b", a_out_data); end
    n_cmp++; if (a_count !== 3'd1) begin n_err++; $display("FAIL bp_count_one: got %0d expected 1", a_count); end
    tick();
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty_valid: got %0b expected 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'h0) begin n_err++; $display("FAIL bp_empty_data: got %0h expected 0", a_out_data); end
    n_cmp++; if (a_stall !== 16'd4) begin n_err++; $display("FAIL bp_stall_hold: got %0d expected 4", a_stall); end
  endtask

  task automatic test_flush();
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h1;
    tick();
    a_in_data = 32'h2;
    tick();
    n_cmp++; if (a_count !== 3'd2) begin n_err++; $display("FAIL flush_prefill: got %0d expected 2", a_count); end
    a_flush = 1; a_in_valid = 1; a_in_data = 32'hC;
    #1;
    n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b expected 0", a_in_ready); end
    tick();
    n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", a_count); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %0b expected 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 32'h0) begin n_err++; $display("FAIL flush_out_data: got %0h expected 0", a_out_data); end
    n_cmp++; if (a_stall !== 16'd6) begin n_err++; $display("FAIL flush_stall: got %0d expected 6", a_stall); end
    a_flush = 0; a_in_valid = 1; a_in_data = 32'hD;
    tick();
    a_in_valid = 0;
    n_cmp++; if (a_count !== 3'd1) begin n_err++; $display("FAIL flush_d_count: got %0d expected 1", a_count); end
    n_cmp++; if (a_out_data !== 32'hD) begin n_err++; $display("FAIL flush_d_data: got %0h expected d", a_out_data); end
    a_out_ready = 1;
    tick();
    n_cmp++; if (a_count !== 3'd0) begin n_err++; $display("FAIL flush_d_alone: got %0d expected 0", a_count); end
    n_cmp++; if (a_stall !== 16'd6) begin n_err++; $display("FAIL flush_stall_end: got %0d expected 6", a_stall); end
  endtask

  task automatic test_saturation();
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 32'h77;
    tick();
    s_in_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_cmp++;
      if (s_stall !== 4'((k > 15) ? 15 : k)) begin
        n_err++; $display("FAIL sat_stall[%0d]: got %0d expected %0d", k, s_stall, (k > 15) ? 15 : k);
      end
    end
    n_cmp++; if (s_out_data !== 32'h77) begin n_err++; $display("FAIL sat_data: got %0h expected 77", s_out_data); end
  endtask

  task automatic test_depth3_random();
    logic [31:0] q[$];
    logic        v, r, do_push, do_pop;
    logic [31:0] d;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      c_in_valid = v; c_out_ready = r; c_in_data = d;
      #1;
      n_cmp++; if (c_count !== 3'(q.size())) begin n_err++; $display("FAIL d3_count[%0d]: got %0d expected %0d", cyc, c_count, q.size()); end
      n_cmp++; if (c_out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL d3_out_valid[%0d]: got %0b expected %0b", cyc, c_out_valid, (q.size() != 0)); end
      n_cmp++; if (c_in_ready !== (q.size() < 3)) begin n_err++; $display("FAIL d3_in_ready[%0d]: got %0b expected %0b", cyc, c_in_ready, (q.size() < 3)); end
      if (q.size() != 0) begin
        n_cmp++; if (c_out_data !== q[0]) begin n_err++; $display("FAIL d3_out_data[%0d]: got %0h expected %0h", cyc, c_out_data, q[0]); end
      end
      do_push = v && (q.size() < 3);
      do_pop  = r && (q.size() != 0);
      tick();
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    c_in_valid = 0; c_out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (q.size() != 0) begin
        n_cmp++; if (c_out_data !== q[0]) begin n_err++; $display("FAIL d3_drain_data: got %0h expected %0h", c_out_data, q[0]); end
        void'(q.pop_front());
      end
      tick();
    end
    n_cmp++; if (c_count !== 3'd0) begin n_err++; $display("FAIL d3_drain_count: got %0d expected 0", c_count); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_saturation();
    test_depth3_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
